// File: rtl/controller_pkg.sv
`default_nettype none
// ============================================================================
// controller_pkg : state/opcode-class enums and opcode constants shared by the
//                  multi-cycle controller.            Revision 1.0
// ============================================================================
package controller_pkg;

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        ERR    = 3'd5
    } state_e;

    typedef enum logic [2:0] {
        CLS_LOAD  = 3'd0,
        CLS_STORE = 3'd1,
        CLS_JUMP  = 3'd2,
        CLS_BEQ   = 3'd3,
        CLS_WIN   = 3'd4,
        CLS_ALU   = 3'd5
    } opclass_e;

    localparam logic [3:0] OP_LOAD  = 4'b0000;
    localparam logic [3:0] OP_STORE = 4'b0001;
    localparam logic [3:0] OP_JUMP  = 4'b0010;
    localparam logic [3:0] OP_BEQ   = 4'b0100;
    localparam logic [3:0] OP_WIN   = 4'b1000;

    // Opcodes are compared at a common 32-bit width so any OPCODE_W fits.
    function automatic logic [31:0] op_ext(input logic [3:0] op4);
        return {28'd0, op4};
    endfunction

    function automatic opclass_e op_class(input logic [31:0] op);
        if (op == op_ext(OP_LOAD))       return CLS_LOAD;
        else if (op == op_ext(OP_STORE)) return CLS_STORE;
        else if (op == op_ext(OP_JUMP))  return CLS_JUMP;
        else if (op == op_ext(OP_BEQ))   return CLS_BEQ;
        else if (op == op_ext(OP_WIN))   return CLS_WIN;
        else                             return CLS_ALU;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_wait_timer.sv
`default_nettype none
// ============================================================================
// mem_wait_timer : counts consecutive stalled memory cycles and flags timeout
//                  once MAX_WAIT is reached while still stalled.  Revision 1.0
// ============================================================================
module mem_wait_timer #(
    parameter int MAX_WAIT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear_i,
    input  logic stall_i,
    output logic timeout_o
);
    localparam int                CNT_W   = $clog2(MAX_WAIT + 1);
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(MAX_WAIT);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i)
            cnt_d = '0;
        else if (stall_i && (cnt_q != CNT_MAX))
            cnt_d = cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign timeout_o = stall_i && (cnt_q == CNT_MAX);

endmodule
`default_nettype wire

// File: rtl/multicycle_controller.sv
`default_nettype none
// ============================================================================
// multicycle_controller : fetch/decode/exec/mem/wb sequencer with memory
//                         handshakes and sticky timeout trap.  Revision 1.0
// ============================================================================
module multicycle_controller
    import controller_pkg::*;
#(
    parameter int OPCODE_W = 4,
    parameter int MAX_WAIT = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [OPCODE_W-1:0] instr_op,
    input  logic                imem_ready,
    input  logic                dmem_ready,
    input  logic                zero,
    output logic                readIM,
    output logic                irWrite,
    output logic                pcWrite,
    output logic                selImm,
    output logic                selMemOut,
    output logic                beq,
    output logic                jump,
    output logic                winUpdate,
    output logic                writeFR,
    output logic                writeDM,
    output logic                readDM,
    output logic                instr_done,
    output logic                err
);
    state_e              state_q, state_d;
    logic [OPCODE_W-1:0] op_q, op_d;
    opclass_e            cls;
    logic                wait_stall;
    logic                wait_timeout;

    assign cls = op_class(32'(op_q));

    always_comb begin
        wait_stall = 1'b0;
        if (state_q == FETCH)    wait_stall = !imem_ready;
        else if (state_q == MEM) wait_stall = !dmem_ready;
    end

    mem_wait_timer #(.MAX_WAIT(MAX_WAIT)) u_timer (
        .clk       (clk),
        .rst       (rst),
        .clear_i   (!wait_stall),
        .stall_i   (wait_stall),
        .timeout_o (wait_timeout)
    );

    always_comb begin
        op_d = op_q;
        if ((state_q == FETCH) && imem_ready) op_d = instr_op;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= FETCH;
            op_q    <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
        end
    end

    // Everything is gated by rst so a reset mid-write drops strobes at once.
    always_comb begin
        state_d    = state_q;
        readIM     = 1'b0;
        irWrite    = 1'b0;
        pcWrite    = 1'b0;
        selImm     = 1'b0;
        selMemOut  = 1'b0;
        beq        = 1'b0;
        jump       = 1'b0;
        winUpdate  = 1'b0;
        writeFR    = 1'b0;
        writeDM    = 1'b0;
        readDM     = 1'b0;
        instr_done = 1'b0;
        err        = 1'b0;
        if (!rst) begin
            case (state_q)
                FETCH: begin
                    readIM = 1'b1;
                    if (imem_ready) begin
                        irWrite = 1'b1;
                        pcWrite = 1'b1;
                        state_d = DECODE;
                    end else if (wait_timeout) begin
                        state_d = ERR;
                    end
                end
                DECODE: state_d = EXEC;
                EXEC: begin
                    case (cls)
                        CLS_JUMP: begin
                            jump       = 1'b1;
                            pcWrite    = 1'b1;
                            instr_done = 1'b1;
                            state_d    = FETCH;
                        end
                        CLS_BEQ: begin
                            beq        = 1'b1;
                            pcWrite    = zero;
                            instr_done = 1'b1;
                            state_d    = FETCH;
                        end
                        CLS_LOAD, CLS_STORE: state_d = MEM;
                        CLS_ALU: begin
                            selImm  = 1'b1;
                            state_d = WB;
                        end
                        default: state_d = WB;
                    endcase
                end
                MEM: begin
                    writeDM = (cls == CLS_STORE);
                    readDM  = (cls != CLS_STORE);
                    if (dmem_ready) begin
                        instr_done = (cls == CLS_STORE);
                        state_d    = (cls == CLS_STORE) ? FETCH : WB;
                    end else if (wait_timeout) begin
                        state_d = ERR;
                    end
                end
                WB: begin
                    writeFR    = 1'b1;
                    instr_done = 1'b1;
                    selMemOut  = (cls == CLS_LOAD);
                    selImm     = (cls == CLS_ALU);
                    winUpdate  = (cls == CLS_WIN);
                    state_d    = FETCH;
                end
                ERR:     err = 1'b1;
                default: state_d = FETCH;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_multicycle_controller.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// tb_multicycle_controller : randomized bench against a per-cycle expected
//                            output trace built from the instruction rules.
// ============================================================================
module tb_multicycle_controller;
    localparam int OPW = 6;
    localparam int MW  = 4;

    localparam logic [12:0] B_RIM  = 13'h1000;
    localparam logic [12:0] B_IRW  = 13'h0800;
    localparam logic [12:0] B_PCW  = 13'h0400;
    localparam logic [12:0] B_IMM  = 13'h0200;
    localparam logic [12:0] B_MEMO = 13'h0100;
    localparam logic [12:0] B_BEQ  = 13'h0080;
    localparam logic [12:0] B_JMP  = 13'h0040;
    localparam logic [12:0] B_WIN  = 13'h0020;
    localparam logic [12:0] B_WFR  = 13'h0010;
    localparam logic [12:0] B_WDM  = 13'h0008;
    localparam logic [12:0] B_RDM  = 13'h0004;
    localparam logic [12:0] B_DONE = 13'h0002;
    localparam logic [12:0] B_ERR  = 13'h0001;

    logic           clk = 1'b0;
    logic           rst;
    logic [OPW-1:0] instr_op;
    logic           imem_ready, dmem_ready, zero;
    logic           readIM, irWrite, pcWrite, selImm, selMemOut, beq, jump;
    logic           winUpdate, writeFR, writeDM, readDM, instr_done, err;
    logic [12:0]    ov;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct packed {
        logic [12:0]    exp;
        logic           imem;
        logic           dmem;
        logic           zr;
        logic [OPW-1:0] op;
    } step_t;

    step_t       seq[$];
    logic [12:0] obs[$];

    always #5 clk = ~clk;

    multicycle_controller #(.OPCODE_W(OPW), .MAX_WAIT(MW)) dut (
        .clk(clk), .rst(rst), .instr_op(instr_op), .imem_ready(imem_ready),
        .dmem_ready(dmem_ready), .zero(zero), .readIM(readIM), .irWrite(irWrite),
        .pcWrite(pcWrite), .selImm(selImm), .selMemOut(selMemOut), .beq(beq),
        .jump(jump), .winUpdate(winUpdate), .writeFR(writeFR), .writeDM(writeDM),
        .readDM(readDM), .instr_done(instr_done), .err(err)
    );

    assign ov = {readIM, irWrite, pcWrite, selImm, selMemOut, beq, jump,
                 winUpdate, writeFR, writeDM, readDM, instr_done, err};

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic logic [OPW-1:0] rop();
        return OPW'($urandom);
    endfunction

    function automatic void push(logic [12:0] e, logic im, logic dm, logic z, logic [OPW-1:0] op);
        step_t s;
        s.exp = e; s.imem = im; s.dmem = dm; s.zr = z; s.op = op;
        seq.push_back(s);
    endfunction

    // Expected cycle trace of one instruction: fst fetch stalls, mst data stalls;
    // more than MW consecutive stalls traps and is followed by four ERR cycles.
    function automatic void build(logic [OPW-1:0] op, logic z, int fst, int mst);
        bit          is_ld  = (op == 0);
        bit          is_st  = (op == 1);
        bit          is_j   = (op == 2);
        bit          is_bq  = (op == 4);
        bit          is_win = (op == 8);
        bit          is_alu = !(is_ld || is_st || is_j || is_bq || is_win);
        logic [12:0] acc;
        for (int i = 0; i < fst && i <= MW; i++) push(B_RIM, 1'b0, rb(), rb(), rop());
        if (fst > MW) begin
            for (int i = 0; i < 4; i++) push(B_ERR, rb(), 1'b1, rb(), rop());
            return;
        end
        push(B_RIM | B_IRW | B_PCW, 1'b1, rb(), rb(), op);
        push(13'h0, rb(), rb(), rb(), rop());
        if (is_j) begin
            push(B_JMP | B_PCW | B_DONE, rb(), rb(), rb(), rop());
            return;
        end
        if (is_bq) begin
            push(B_BEQ | (z ? B_PCW : 13'h0) | B_DONE, rb(), rb(), z, rop());
            return;
        end
        push(is_alu ? B_IMM : 13'h0, rb(), rb(), rb(), rop());
        if (is_ld || is_st) begin
            acc = is_ld ? B_RDM : B_WDM;
            for (int i = 0; i < mst && i <= MW; i++) push(acc, rb(), 1'b0, rb(), rop());
            if (mst > MW) begin
                for (int i = 0; i < 4; i++) push(B_ERR, rb(), 1'b1, rb(), rop());
                return;
            end
            push(acc | (is_st ? B_DONE : 13'h0), rb(), 1'b1, rb(), rop());
            if (is_st) return;
        end
        push(B_WFR | B_DONE | (is_ld ? B_MEMO : 13'h0) | (is_alu ? B_IMM : 13'h0)
             | (is_win ? B_WIN : 13'h0), rb(), rb(), rb(), rop());
    endfunction

    task automatic apply_seq();
        obs.delete();
        foreach (seq[i]) begin
            instr_op   = seq[i].op;
            imem_ready = seq[i].imem;
            dmem_ready = seq[i].dmem;
            zero       = seq[i].zr;
            #3;
            obs.push_back(ov);
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; instr_op = rop(); imem_ready = 1'b1; dmem_ready = 1'b1; zero = 1'b1;
        repeat (2) @(posedge clk);
        #3;
        n_tests++;
        if (ov !== 13'h0) begin
            n_fail++; $display("FAIL reset_outputs: got %b expected %b", ov, 13'h0);
        end
        @(posedge clk); #1;
        rst = 1'b0; imem_ready = 1'b0;
        #3;
        n_tests++;
        if (ov !== B_RIM) begin
            n_fail++; $display("FAIL reset_release: got %b expected %b", ov, B_RIM);
        end
    endtask

    task automatic test_load_stall();
        seq.delete();
        build(6'd0, 1'b0, 0, 2);
        apply_seq();
        foreach (seq[i]) begin
            n_tests++;
            if (obs[i] !== seq[i].exp) begin
                n_fail++; $display("FAIL load_stall step %0d: got %b expected %b", i, obs[i], seq[i].exp);
            end
        end
    endtask

    task automatic test_beq();
        seq.delete();
        build(6'd4, 1'b1, 0, 0);
        build(6'd4, 1'b0, 0, 0);
        apply_seq();
        foreach (seq[i]) begin
            n_tests++;
            if (obs[i] !== seq[i].exp) begin
                n_fail++; $display("FAIL beq step %0d: got %b expected %b", i, obs[i], seq[i].exp);
            end
        end
    endtask

    task automatic test_store();
        seq.delete();
        build(6'd1, 1'b0, 0, 0);
        apply_seq();
        foreach (seq[i]) begin
            n_tests++;
            if (obs[i] !== seq[i].exp) begin
                n_fail++; $display("FAIL store step %0d: got %b expected %b", i, obs[i], seq[i].exp);
            end
        end
    endtask

    task automatic test_opcode_width();
        seq.delete();
        build(6'b100000, rb(), 1, 0);
        build(6'b001000, rb(), 0, 0);
        apply_seq();
        foreach (seq[i]) begin
            n_tests++;
            if (obs[i] !== seq[i].exp) begin
                n_fail++; $display("FAIL opcode_width step %0d: got %b expected %b", i, obs[i], seq[i].exp);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [OPW-1:0] op;
        seq.delete();
        for (int k = 0; k < 40; k++) begin
            case ($urandom_range(0, 5))
                0: op = 6'd0;
                1: op = 6'd1;
                2: op = 6'd2;
                3: op = 6'd4;
                4: op = 6'd8;
                default: op = rop();
            endcase
            build(op, rb(), $urandom_range(0, MW), $urandom_range(0, MW));
        end
        apply_seq();
        foreach (seq[i]) begin
            n_tests++;
            if (obs[i] !== seq[i].exp) begin
                n_fail++; $display("FAIL back_to_back step %0d: got %b expected %b", i, obs[i], seq[i].exp);
            end
        end
    endtask

    task automatic test_timeout(input bit in_fetch);
        seq.delete();
        if (in_fetch) build(rop(), 1'b0, MW + 1, 0);
        else          build(6'd0, 1'b0, 0, MW + 1);
        apply_seq();
        foreach (seq[i]) begin
            n_tests++;
            if (obs[i] !== seq[i].exp) begin
                n_fail++; $display("FAIL timeout_%0d step %0d: got %b expected %b", in_fetch, i, obs[i], seq[i].exp);
            end
        end
        rst = 1'b1;
        #1;
        n_tests++;
        if (ov !== 13'h0) begin
            n_fail++; $display("FAIL timeout_reset: got %b expected %b", ov, 13'h0);
        end
        @(posedge clk); #1;
        rst = 1'b0; imem_ready = 1'b0;
        #3;
        n_tests++;
        if (ov !== B_RIM) begin
            n_fail++; $display("FAIL timeout_release: got %b expected %b", ov, B_RIM);
        end
    endtask

    task automatic test_mid_reset();
        step_t last;
        seq.delete();
        build(6'd8, 1'b0, 0, 0);
        last = seq.pop_back();
        apply_seq();
        foreach (seq[i]) begin
            n_tests++;
            if (obs[i] !== seq[i].exp) begin
                n_fail++; $display("FAIL mid_reset step %0d: got %b expected %b", i, obs[i], seq[i].exp);
            end
        end
        instr_op = last.op; imem_ready = last.imem; dmem_ready = last.dmem; zero = last.zr;
        #3;
        n_tests++;
        if (ov !== last.exp) begin
            n_fail++; $display("FAIL mid_reset_wb: got %b expected %b", ov, last.exp);
        end
        rst = 1'b1;
        #1;
        n_tests++;
        if (ov !== 13'h0) begin
            n_fail++; $display("FAIL mid_reset_drop: got %b expected %b", ov, 13'h0);
        end
        @(posedge clk); #1;
        rst = 1'b0; imem_ready = 1'b0;
        #3;
        n_tests++;
        if (ov !== B_RIM) begin
            n_fail++; $display("FAIL mid_reset_release: got %b expected %b", ov, B_RIM);
        end
    endtask

    initial begin
        test_reset();
        test_load_stall();
        test_beq();
        test_store();
        test_opcode_width();
        test_timeout(1'b0);
        test_mid_reset();
        test_back_to_back();
        test_timeout(1'b1);
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
